// File: rtl/fir_pkg.sv
// Shared definitions for the FIR result capture/drain path.
//   state_e        : capture-sink FSM states
//   BYTES_PER_WORD : bytes shipped per captured sample
//   FLOAT_W        : width of one filter result (float32, treated as opaque bits)
package fir_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int FLOAT_W        = 32;

  typedef enum logic [2:0] {
    ST_CAPTURE = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/fir_result_sink_sample_buffer.sv
// sample_buffer: simple dual-port sample store, one write port and one read
// port with a registered (1-cycle) read. Contents are not reset so the array
// maps onto block RAM.
//   clk     : clock
//   wr_en   : write wr_data at wr_addr on this edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every edge
//   rd_data : word at rd_addr as of the previous edge
module sample_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_result_sink.sv
// fir_result_sink: captures N_SAMPLES filter results into a buffer, then
// drains them MSB byte first over a byte stream towards the UART transmitter.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : in_data carries a filter result this cycle
//   in_data     : filter result (opaque 32-bit word)
//   restart     : pulse; in DONE starts a new capture run
//   tx_valid    : tx_data holds a byte for the transmitter
//   tx_data     : byte to transmit
//   tx_ready    : transmitter takes the byte
//   capturing   : FSM is in CAPTURE
//   done        : FSM is in DONE
//   overflow    : sticky, a sample arrived while not capturing
//   wr_count    : samples captured in the current run
//
// Handshake: a byte moves on every edge where tx_valid && tx_ready. Once
// tx_valid is high, tx_valid and tx_data hold until that edge (only rst can
// drop them early).
module fir_result_sink
  import fir_pkg::*;
#(
  parameter int N_SAMPLES = 1000,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              restart,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              capturing,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  localparam logic [ADDR_W:0]   LAST_WR   = (ADDR_W+1)'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] LAST_RD   = ADDR_W'(N_SAMPLES - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                overflow_q, overflow_d;
  logic                buf_we;
  logic [DATA_W-1:0]   rd_data;

  sample_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_count_q[ADDR_W-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    rd_addr_d  = rd_addr_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
    buf_we     = 1'b0;

    // Any sample outside CAPTURE is dropped and flagged, including one that
    // coincides with restart in DONE.
    if (in_valid && (state_q != ST_CAPTURE)) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_CAPTURE: begin
        if (in_valid) begin
          buf_we     = 1'b1;
          wr_count_d = wr_count_q + (ADDR_W+1)'(1);
          if (wr_count_q == LAST_WR) begin
            state_d   = ST_FETCH;
            rd_addr_d = '0;
          end
        end
      end
      ST_FETCH: begin
        // rd_addr_q is on the buffer read port; the word appears in LOAD.
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d    = rd_data;
        tx_data_d  = rd_data[DATA_W-1 -: 8];
        tx_valid_d = 1'b1;
        byte_idx_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (byte_idx_q != LAST_BYTE) begin
            // Next byte is the one just below the current top byte.
            shift_d    = shift_q << 8;
            tx_data_d  = shift_q[DATA_W-9 -: 8];
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            tx_valid_d = 1'b0;
            if (rd_addr_q == LAST_RD) begin
              state_d = ST_DONE;
            end else begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
              state_d   = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: begin
        if (restart) begin
          wr_count_d = '0;
          rd_addr_d  = '0;
          state_d    = ST_CAPTURE;
        end
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CAPTURE;
      wr_count_q <= '0;
      rd_addr_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_addr_q  <= rd_addr_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;
  assign wr_count  = wr_count_q;
  assign capturing = (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fir_result_sink.sv
// Bench for fir_result_sink: a 4-sample instance (full address space) driven
// through directed scenarios against a queue-based model, and a 1000-sample
// instance fed gapped index data.
module tb_fir_result_sink;

  localparam int N4 = 4;
  localparam int A4 = 2;
  localparam int NK = 1000;
  localparam int AK = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic        in4_valid, restart4;
  logic [31:0] in4_data;
  logic        ready4 = 1'b1;
  logic        tx4_valid, cap4, done4, ovf4;
  logic [7:0]  tx4_data;
  logic [A4:0] wrc4;

  logic        ink_valid, restartk;
  logic [31:0] ink_data;
  logic        readyk = 1'b1;
  logic        txk_valid, capk, donek, ovfk;
  logic [7:0]  txk_data;
  logic [AK:0] wrck;

  fir_result_sink #(.N_SAMPLES(N4), .ADDR_W(A4), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_data(in4_data),
    .restart(restart4), .tx_valid(tx4_valid), .tx_data(tx4_data),
    .tx_ready(ready4), .capturing(cap4), .done(done4), .overflow(ovf4),
    .wr_count(wrc4)
  );

  fir_result_sink #(.N_SAMPLES(NK), .ADDR_W(AK), .DATA_W(32)) u_dutk (
    .clk(clk), .rst(rst), .in_valid(ink_valid), .in_data(ink_data),
    .restart(restartk), .tx_valid(txk_valid), .tx_data(txk_data),
    .tx_ready(readyk), .capturing(capk), .done(donek), .overflow(ovfk),
    .wr_count(wrck)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of the 4-sample instance: what is captured, what bytes are owed.
  bit          mcap = 1'b1;
  int          mcnt = 0;
  bit          movf = 1'b0;
  logic [31:0] mbuf[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    bit done_now;
    done_now = !mcap && (exp_q.size() == 0);
    chk("capturing", {31'd0, cap4}, {31'd0, mcap});
    chk("done", {31'd0, done4}, {31'd0, done_now});
    chk("overflow", {31'd0, ovf4}, {31'd0, movf});
    chk("wr_count", 32'(wrc4), 32'(mcnt));
    if (mcap || done_now) chk("tx_valid_idle", {31'd0, tx4_valid}, 32'd0);
    if (stall_prev) begin
      chk("stall_valid", {31'd0, tx4_valid}, 32'd1);
      chk("stall_data", {24'd0, tx4_data}, {24'd0, prev_data});
    end
    if (tx4_valid === 1'b1 && ready4) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %0h expected no byte", tx4_data);
      end else begin
        chk("byte", {24'd0, tx4_data}, {24'd0, exp_q.pop_front()});
      end
      got_q.push_back(tx4_data);
    end
    // Advance the model by the upcoming edge.
    if (rst) begin
      mcap = 1'b1; mcnt = 0; movf = 1'b0;
      mbuf.delete(); exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (in4_valid) begin
        if (mcap) begin
          mbuf.push_back(in4_data);
          mcnt++;
          if (mcnt == N4) begin
            mcap = 1'b0;
            foreach (mbuf[i])
              for (int b = 3; b >= 0; b--) exp_q.push_back(mbuf[i][8*b +: 8]);
            mbuf.delete();
          end
        end else begin
          movf = 1'b1;
        end
      end
      if (restart4 && done_now) begin
        mcap = 1'b1;
        mcnt = 0;
      end
      stall_prev = (tx4_valid === 1'b1) && !ready4;
      prev_data  = tx4_data;
    end
  end

  // 1000-sample instance: byte k must be byte (k%4) of word k/4 = index.
  int kcnt = 0;
  always @(negedge clk) begin
    logic [31:0] kword;
    if (!rst && txk_valid === 1'b1 && readyk) begin
      kword = 32'(kcnt / 4);
      chk("k_byte", {24'd0, txk_data}, (kword >> (8 * (3 - kcnt % 4))) & 32'hFF);
      kcnt++;
    end
  end

  // ---------------- ready drivers ----------------
  int ready_mode = 0;  // 0 high, 1 random, 2 low
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready4 = 1'b1;
      1:       ready4 = 1'($urandom_range(0, 1));
      default: ready4 = 1'b0;
    endcase
    readyk = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send4(input logic [31:0] d);
    in4_valid = 1'b1;
    in4_data  = d;
    @(posedge clk); #1;
    in4_valid = 1'b0;
  endtask

  task automatic pulse_restart4();
    restart4 = 1'b1;
    @(posedge clk); #1;
    restart4 = 1'b0;
  endtask

  task automatic wait_done4(input int budget);
    int n = 0;
    while (done4 !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL wait_done4: done=%b after %0d cycles, expected 1", done4, n);
    end
  endtask

  task automatic wait_bytes(input int cnt, input int budget);
    int n = 0;
    while (got_q.size() < cnt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (got_q.size() < cnt) begin
      errors++;
      $display("FAIL wait_bytes: got %0d bytes expected %0d", got_q.size(), cnt);
    end
  endtask

  logic [7:0] lit_bytes [16];

  task automatic check_lit(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk({name, "_lit"}, {24'd0, got_q[i]}, {24'd0, lit_bytes[i]});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence ----------------
  initial begin
    lit_bytes = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00,
                  8'hBF, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1;
    in4_valid = 1'b0; in4_data = '0; restart4 = 1'b0;
    ink_valid = 1'b0; ink_data = '0; restartk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'd0, tx4_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx4_data}, 32'd0);
    chk("rst_capturing", {31'd0, cap4}, 32'd1);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_overflow", {31'd0, ovf4}, 32'd0);
    chk("rst_wr_count", 32'(wrc4), 32'd0);
    chk("rst_k_capturing", {31'd0, capk}, 32'd1);
    rst = 1'b0;

    // Basic run with tx_ready high, plus first-byte latency.
    got_q.delete();
    send4(32'h3F800000);
    send4(32'h40000000);
    send4(32'hBF800000);
    send4(32'h00000000);
    chk("lat_edge0", {31'd0, tx4_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge1", {31'd0, tx4_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", {31'd0, tx4_valid}, 32'd1);
    chk("lat_first_byte", {24'd0, tx4_data}, 32'h3F);
    wait_done4(200);
    check_lit("basic");

    // Backpressure: random ready, 20-cycle stall mid-word, ignored restart.
    pulse_restart4();
    got_q.delete();
    ready_mode = 1;
    send4(32'h3F800000);
    send4(32'h40000000);
    send4(32'hBF800000);
    send4(32'h00000000);
    wait_bytes(5, 300);
    ready_mode = 2;
    repeat (10) @(posedge clk);
    #1;
    pulse_restart4();
    repeat (10) @(posedge clk);
    #1;
    chk("stall_still_valid", {31'd0, tx4_valid}, 32'd1);
    ready_mode = 1;
    wait_done4(500);
    check_lit("backpressure");

    // Overflow during SEND; sticky across restart, cleared by rst.
    pulse_restart4();
    got_q.delete();
    ready_mode = 0;
    send4(32'h3F800000);
    send4(32'h40000000);
    send4(32'hBF800000);
    send4(32'h00000000);
    wait_bytes(2, 50);
    send4(32'hDEADBEEF);
    chk("ovf_set", {31'd0, ovf4}, 32'd1);
    wait_done4(200);
    check_lit("overflow");
    pulse_restart4();
    chk("ovf_after_restart", {31'd0, ovf4}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ovf_after_rst", {31'd0, ovf4}, 32'd0);

    // Reset mid-drain after 6 bytes, then a fresh run.
    got_q.delete();
    send4(32'h01020304);
    send4(32'h05060708);
    send4(32'h090A0B0C);
    send4(32'h0D0E0F10);
    wait_bytes(6, 50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_tx_valid", {31'd0, tx4_valid}, 32'd0);
    chk("mid_rst_wr_count", 32'(wrc4), 32'd0);
    chk("mid_rst_capturing", {31'd0, cap4}, 32'd1);
    got_q.delete();
    send4(32'h12345678);
    send4(32'h9ABCDEF0);
    send4(32'h0F0F0F0F);
    send4(32'hFFFFFFFF);
    wait_done4(200);
    chk("fresh_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      chk("fresh_first", {24'd0, got_q[0]}, 32'h12);
      chk("fresh_fifth", {24'd0, got_q[4]}, 32'h9A);
      chk("fresh_last", {24'd0, got_q[15]}, 32'hFF);
    end

    // Restart together with in_valid in DONE.
    in4_valid = 1'b1;
    in4_data  = 32'h11111111;
    restart4  = 1'b1;
    @(posedge clk); #1;
    in4_valid = 1'b0;
    restart4  = 1'b0;
    chk("rs_capturing", {31'd0, cap4}, 32'd1);
    chk("rs_overflow", {31'd0, ovf4}, 32'd1);
    chk("rs_wr_count", 32'(wrc4), 32'd0);
    got_q.delete();
    send4(32'hCAFEBABE);
    send4(32'h00000001);
    send4(32'h80000000);
    send4(32'h7F7FFFFF);
    wait_done4(200);
    chk("rs_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      chk("rs_first", {24'd0, got_q[0]}, 32'hCA);
      chk("rs_byte7", {24'd0, got_q[7]}, 32'h01);
      chk("rs_byte8", {24'd0, got_q[8]}, 32'h80);
    end

    // Gapped 1000-sample run: valid every 3rd cycle, data = index.
    for (int i = 0; i < NK; i++) begin
      ink_valid = 1'b1;
      ink_data  = 32'(i);
      @(posedge clk); #1;
      ink_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    chk("k_wr_count", 32'(wrck), 32'd1000);
    chk("k_capturing", {31'd0, capk}, 32'd0);
    begin
      int n = 0;
      while (donek !== 1'b1 && n < 20000) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("k_done", {31'd0, donek}, 32'd1);
    chk("k_byte_total", 32'(kcnt), 32'd4000);
    chk("k_overflow", {31'd0, ovfk}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
